dpb_pkt_fifo: RTL
=================

# dpb_pkt_fifo

Parametrised single-clock packet FIFO built on inferred simple-dual-port block RAM. It replaces fixed 1024x64 dual-port RAM instances in the CAM2PC_BYUDP datapath: camera-side logic writes frame-slice packets, and the UDP transmitter reads back only whole, committed packets. A packet in progress can be rolled back explicitly or automatically on overflow, and read latency is selectable with an optional output register.

## Interface
- DATA_W, 64, payload width in bits; the RAM stores DATA_W+1 bits per word (payload plus last flag)
- ADDR_W, 10, address width; DEPTH = 2^ADDR_W words
- OUT_REG, 1, 0 gives read latency 1; 1 adds an output register for read latency 2
- clk  in  1  single clock; the only clock in the block
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write payload
- wr_last  in  1  marks the final word of a packet
- wr_drop  in  1  roll back the open packet
- wr_full  out  1  no free word for a write
- rd_en  in  1  read request
- rd_empty  out  1  no committed word available to read
- rd_valid  out  1  rd_data and rd_last are valid this cycle
- rd_data  out  DATA_W  read payload
- rd_last  out  1  last flag of the word being read out
- pkt_count  out  ADDR_W+1  committed packets not yet fully read out
- err_clr  in  1  clears err_ovf
- err_ovf  out  1  sticky flag; set when a packet is discarded because of overflow

## Operation
- Pointers wr_ptr, cmt_ptr and rd_ptr are each ADDR_W+1 bits wide; the low ADDR_W bits address the RAM and the MSB handles wrap-around.
- wr_full = (wr_ptr - rd_ptr == DEPTH). rd_empty = (rd_ptr == cmt_ptr). Both are decoded from registers only.
- Write-side state machine has three states:
  - IDLE: no packet is open.
  - PKT: a packet is partially written.
  - DISC: the rest of an overflowed packet is being discarded.
- Write acceptance, in IDLE or PKT: when wr_en=1 and wr_full=0 and wr_drop=0:
  - RAM[wr_ptr] <= {wr_last, wr_data}; wr_ptr increments.
  - If wr_last=1: cmt_ptr <= wr_ptr+1, pkt_count increments, and the state goes to IDLE.
  - If wr_last=0: the state goes to PKT.
- Overflow: wr_en=1 with wr_full=1, in IDLE or PKT:
  - The word is not stored, wr_ptr <= cmt_ptr, and err_ovf <= 1.
  - If wr_last=1, the state goes to IDLE; otherwise it goes to DISC.
- DISC: every wr_en word is ignored. wr_en=1 with wr_last=1 returns the state to IDLE, with no commit.
- wr_drop=1 in any state: wr_ptr <= cmt_ptr and the state goes to IDLE. It takes priority over wr_en in the same cycle. In IDLE it is a no-op.
- A packet longer than DEPTH words always overflows and is discarded.
- Read: rd_en=1 with rd_empty=0 issues a RAM read at rd_ptr and rd_ptr increments. rd_en while empty is ignored, with no rd_valid and no error.
- Only the committed region [rd_ptr, cmt_ptr) is ever read, so there is never a read/write address collision.
- pkt_count decrements when rd_valid=1 and rd_last=1. A commit and a decrement in the same cycle leave it unchanged.
- err_ovf: a set in the same cycle as err_clr wins over the clear.
- Reset (honoured mid-packet and mid-read):
  - All pointers and pkt_count go to 0, the state goes to IDLE, and err_ovf goes to 0.
  - Outputs: wr_full=0, rd_empty=1, rd_valid=0, rd_data=0, rd_last=0.
  - Read-pipeline valid bits are cleared. RAM contents are not cleared.

## Timing
- Writes take effect at the clk edge on which they are accepted.
- Commit happens at the edge that accepts wr_last. rd_empty falls immediately after that edge, so the earliest rd_en is the next cycle.
- Read latency is 1+OUT_REG cycles: rd_en accepted at edge N gives rd_valid=1 during the cycle after edge N+OUT_REG.
- There is no read back-pressure. Consecutive rd_en cycles give one valid word per cycle.
- Freed space is visible on wr_full the cycle after the read edge. Rolled-back space is visible the cycle after the wr_drop or overflow edge.
- No combinational path exists from any input to any output.

## Test plan
Bench uses DATA_W=64, ADDR_W=4, OUT_REG covering both 0 and 1.
- Basic: write a 3-word packet A0..A2 (wr_last on A2), then assert rd_en for 3 cycles.
  - Required: rd_data=A0,A1,A2 on consecutive cycles, with rd_last only on A2.
  - Required: first rd_valid exactly 1+OUT_REG cycles after the first rd_en.
  - Required: pkt_count goes 0→1→0.
- Visibility and drop: write 5 words without wr_last, then pulse wr_drop, then write a 2-word packet.
  - Required: rd_empty stays 1 throughout the first 5 words.
  - Required: after the drop, wr_ptr returns to its pre-packet value.
  - Required: only the 2-word packet is read back.
- Overflow: write a 20-word packet into the empty FIFO.
  - Required: wr_full=1 after the 16th word; err_ovf=1 on the 17th write attempt.
  - Required: words 17..20 are ignored, and wr_last on word 20 returns the state to IDLE.
  - Required: pkt_count=0, rd_empty=1, and err_clr clears err_ovf.
- Wrap-around: 10 rounds of a 7-word packet written and then fully read.
  - Required: pointers wrap past 16 and all data matches.
  - Required: wr_full is never asserted spuriously.
- Simultaneous events: commit a packet while the read side emits the rd_last of a previous packet.
  - Required: pkt_count unchanged.
  - Also required: wr_drop in the same cycle as wr_en leaves the word unstored.
- Reset mid-operation: assert reset during a 4-word read burst and an open write packet.
  - Required: next cycle shows rd_valid=0, rd_empty=1, pkt_count=0, wr_full=0.
  - Required: no stale rd_valid appears afterwards.

Source files
------------

// File: rtl/dpb_pkt_fifo.sv
// Single-clock packet FIFO on inferred simple-dual-port RAM. Only committed
// packets are readable; an open packet can be rolled back by request or on overflow.
module dpb_pkt_fifo #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned OUT_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              wr_drop,
  output logic              wr_full,
  input  logic              rd_en,
  output logic              rd_empty,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W:0]   pkt_count,
  input  logic              err_clr,
  output logic              err_ovf
);

  localparam int unsigned     DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, PKT, DISC} wr_state_t;

  logic [DATA_W:0] mem [DEPTH];

  wr_state_t       state, state_n;
  logic [ADDR_W:0] wr_ptr, cmt_ptr, rd_ptr;
  logic            do_acc, do_cmt, do_rb, ovf_set, rd_go, dec;
  logic            ram_v;
  logic [DATA_W:0] ram_q;
  logic            out_v;
  logic [DATA_W:0] out_q;

  assign wr_full  = (wr_ptr - rd_ptr) == DEPTH_P;
  assign rd_empty = (rd_ptr == cmt_ptr);
  assign rd_go    = rd_en & ~rd_empty;

  always_comb begin
    state_n = state;
    do_acc  = 1'b0;
    do_cmt  = 1'b0;
    do_rb   = 1'b0;
    ovf_set = 1'b0;
    if (wr_drop) begin
      do_rb   = 1'b1;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, PKT: begin
          if (wr_en && !wr_full) begin
            do_acc  = 1'b1;
            do_cmt  = wr_last;
            state_n = wr_last ? IDLE : PKT;
          end else if (wr_en) begin
            do_rb   = 1'b1;
            ovf_set = 1'b1;
            state_n = wr_last ? IDLE : DISC;
          end
        end
        DISC: begin
          if (wr_en && wr_last) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
      err_ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (do_rb)       wr_ptr <= cmt_ptr;
      else if (do_acc) wr_ptr <= wr_ptr + 1'b1;
      if (do_cmt)      cmt_ptr <= wr_ptr + 1'b1;
      if (rd_go)       rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)      err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_acc) mem[wr_ptr[ADDR_W-1:0]] <= {wr_last, wr_data};
  end

  // Reads stay inside [rd_ptr, cmt_ptr), so no read/write collision handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_v <= 1'b0;
      ram_q <= '0;
    end else begin
      ram_v <= rd_go;
      if (rd_go) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic            pipe_v;
      logic [DATA_W:0] pipe_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          pipe_v <= 1'b0;
          pipe_q <= '0;
        end else begin
          pipe_v <= ram_v;
          if (ram_v) pipe_q <= ram_q;
        end
      end
      assign out_v = pipe_v;
      assign out_q = pipe_q;
    end else begin : g_no_reg
      assign out_v = ram_v;
      assign out_q = ram_q;
    end
  endgenerate

  assign rd_valid = out_v;
  assign rd_data  = out_q[DATA_W-1:0];
  assign rd_last  = out_q[DATA_W];
  assign dec      = out_v & out_q[DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= '0;
    end else if (do_cmt && !dec) begin
      pkt_count <= pkt_count + 1'b1;
    end else if (dec && !do_cmt) begin
      pkt_count <= pkt_count - 1'b1;
    end
  end

endmodule
